// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon player input path and datapath.
package simon_pkg;

  localparam int PATTERN_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REL_DB   = 3'd3,
    OFFER    = 3'd4
  } state_e;

  // level=1 accepts any non-zero chord; level=0 accepts single buttons only.
  function automatic logic is_legal_pattern(input logic [PATTERN_W-1:0] pat,
                                            input logic                 level);
    if (level) return (pat != '0);
    return (pat != '0) && ((pat & (pat - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/simon_sync.sv
// N-stage synchronizer for asynchronous inputs, cleared to zero on reset.
module simon_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/simon_input_capture.sv
// Debounces the Simon button bus and emits one legality-checked token per
// press-and-release over a valid/ready handshake.
//
// state    | meaning
// IDLE     | waiting for a non-zero synchronized pattern
// PRESS_DB | counting stable samples of the candidate pattern
// HELD     | pattern accepted and frozen, waiting for release
// REL_DB   | counting stable all-zero samples
// OFFER    | token presented until the consumer takes it
module simon_input_capture
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 level,
  input  logic                 entry_en,
  input  logic [PATTERN_W-1:0] pattern_raw,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PATTERN_W-1:0] out_pattern,
  output logic                 out_illegal,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PATTERN_W-1:0] s;
  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] cand_q, cand_d;
  logic [PATTERN_W-1:0] captured_q, captured_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 illegal_q, illegal_d;

  simon_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (PATTERN_W)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pattern_raw),
    .q_o  (s)
  );

  // The edge that sees the final stable sample is the one that transitions,
  // so the count reaching DEBOUNCE_CYCLES is detected at CNT_LAST.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    captured_d = captured_q;
    illegal_d  = 1'b0;
    if (!entry_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (s != '0) begin
            state_d = PRESS_DB;
            cand_d  = s;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_DB: begin
          if (s == '0) begin
            state_d = IDLE;
          end else if (s == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d    = HELD;
              captured_d = cand_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cand_d = s;
            cnt_d  = CNT_ONE;
          end
        end
        HELD: begin
          if (s == '0) begin
            state_d = REL_DB;
            cnt_d   = CNT_ONE;
          end
        end
        REL_DB: begin
          if (s != '0) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            if (is_legal_pattern(captured_q, level)) begin
              state_d = OFFER;
            end else begin
              state_d   = IDLE;
              illegal_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        OFFER: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      captured_q <= '0;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      captured_q <= captured_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign out_valid   = (state_q == OFFER);
  assign out_pattern = captured_q;
  assign out_illegal = illegal_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_simon_input_capture.sv
// Scoreboard bench for simon_input_capture: directed presses push expected
// tokens, a negedge monitor pops them on every completed transfer.
module tb_simon_input_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       level;
  logic       entry_en;
  logic [3:0] pattern_raw;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_pattern;
  logic       out_illegal;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ill_seen = 0;
  int ill_exp  = 0;
  logic [3:0] exp_q [$];

  simon_input_capture #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (level),
    .entry_en   (entry_en),
    .pattern_raw(pattern_raw),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_pattern(out_pattern),
    .out_illegal(out_illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected token.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_token", {28'd0, out_pattern}, 32'hFFFF_FFFF);
      end else begin
        check("token_pattern", {28'd0, out_pattern}, {28'd0, exp_q.pop_front()});
      end
    end
    if (rst_n === 1'b1 && out_illegal === 1'b1) ill_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (out_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic press_release(input logic [3:0] pat, input int hold);
    pattern_raw = pat;
    ticks(hold);
    pattern_raw = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; level = 1'b0; entry_en = 1'b1; pattern_raw = 4'b0000; out_ready = 1'b1;
    #3;
    check("reset_valid",   {31'd0, out_valid},   32'd0);
    check("reset_pattern", {28'd0, out_pattern}, 32'd0);
    check("reset_illegal", {31'd0, out_illegal}, 32'd0);
    check("reset_busy",    {31'd0, busy},        32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // Clean press with exact release latency
    exp_q.push_back(4'b0100);
    press_release(4'b0100, 10);
    ticks(5);
    check("clean_valid_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("clean_valid_edge5", {31'd0, out_valid}, 32'd1);
    check("clean_pattern", {28'd0, out_pattern}, 32'h4);
    tick();
    check("clean_valid_drop", {31'd0, out_valid}, 32'd0);
    ticks(4);

    // Bounce on press and a one-cycle glitch during release
    exp_q.push_back(4'b0010);
    pattern_raw = 4'b0010; ticks(2);
    pattern_raw = 4'b0000; ticks(1);
    pattern_raw = 4'b0010; ticks(8);
    pattern_raw = 4'b0000; ticks(2);
    pattern_raw = 4'b0010; ticks(1);
    pattern_raw = 4'b0000;
    ticks(5);
    check("bounce_valid_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("bounce_valid_edge5", {31'd0, out_valid}, 32'd1);
    ticks(5);

    // Illegal chord at level 0: one-cycle pulse, no token
    ill_exp++;
    press_release(4'b0110, 8);
    begin
      int k = 0;
      while (out_illegal !== 1'b1 && k < 20) begin
        tick();
        k++;
      end
      check("illegal_pulse", {31'd0, out_illegal}, 32'd1);
      check("illegal_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
      check("illegal_pulse_width", {31'd0, out_illegal}, 32'd0);
    end
    ticks(4);

    // Same chord at level 1 is a legal token
    level = 1'b1;
    exp_q.push_back(4'b0110);
    press_release(4'b0110, 8);
    wait_valid(20, "level1_valid");
    ticks(4);
    level = 1'b0;

    // Backpressure: token held while raw input toggles
    out_ready = 1'b0;
    exp_q.push_back(4'b1000);
    press_release(4'b1000, 8);
    wait_valid(20, "bp_valid");
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        pattern_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
        tick();
        if (out_valid !== 1'b1 || out_pattern !== 4'b1000) bad++;
      end
      check("bp_hold_errors", bad, 32'd0);
    end
    pattern_raw = 4'b0000;
    ticks(3);
    out_ready = 1'b1;
    tick();
    check("bp_after_transfer", {31'd0, out_valid}, 32'd0);
    begin
      int extra = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (out_valid === 1'b1) extra++;
      end
      check("bp_no_second_token", extra, 32'd0);
    end

    // Abort while HELD, then re-debounce the still-held press
    pattern_raw = 4'b0001;
    ticks(8);
    check("abort_held_busy_before", {31'd0, busy}, 32'd1);
    entry_en = 1'b0;
    tick();
    check("abort_held_busy", {31'd0, busy}, 32'd0);
    check("abort_held_valid", {31'd0, out_valid}, 32'd0);
    entry_en = 1'b1;
    ticks(8);
    check("abort_held_no_token_while_held", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(4'b0001);
    pattern_raw = 4'b0000;
    wait_valid(20, "abort_held_retoken");
    ticks(3);

    // Abort while OFFER: token discarded
    out_ready = 1'b0;
    press_release(4'b0100, 8);
    wait_valid(20, "abort_offer_valid");
    entry_en = 1'b0;
    tick();
    check("abort_offer_valid_drop", {31'd0, out_valid}, 32'd0);
    check("abort_offer_busy", {31'd0, busy}, 32'd0);
    entry_en = 1'b1;
    out_ready = 1'b1;
    ticks(5);
    check("abort_offer_stays_idle", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset during release debounce
    pattern_raw = 4'b1000;
    ticks(8);
    pattern_raw = 4'b0000;
    ticks(3);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",   {31'd0, out_valid},   32'd0);
    check("rst_mid_busy",    {31'd0, busy},        32'd0);
    check("rst_mid_pattern", {28'd0, out_pattern}, 32'd0);
    check("rst_mid_illegal", {31'd0, out_illegal}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    begin
      int spur = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (out_valid === 1'b1 || busy === 1'b1) spur++;
      end
      check("rst_mid_no_spurious", spur, 32'd0);
    end

    check("tokens_left", exp_q.size(), 32'd0);
    check("illegal_count", ill_seen, ill_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_input_capture.md
Name: simon_input_capture

Overview:
Front end of the Simon player input path. It takes the raw 4-bit button/switch bus and produces one clean, debounced, legality-checked pattern token per press-and-release. Each token goes to the Simon datapath/control over a valid/ready handshake. Tokens are offered on release, so a held button yields exactly one entry.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to accept a press or a release (legal range 2..1023)
SYNC_STAGES, 2, flops in the input synchronizer (legal range 2..3)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  reset; asynchronous assert, active-low
level  input  1  1 = any non-zero pattern is legal; 0 = pattern must be one-hot
entry_en  input  1  control permits player entry; 0 aborts any capture in progress
pattern_raw  input  4  asynchronous button/switch inputs
out_ready  input  1  consumer accepts the token this cycle
out_valid  output  1  token available
out_pattern  output  4  captured pattern; stable while out_valid=1
out_illegal  output  1  one-cycle pulse: a completed press was rejected as illegal
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE, synchronizer flops=0, counter=0, captured=0. Outputs: out_valid=0, out_pattern=4'b0000, out_illegal=0, busy=0.
- Synchronizer: SYNC_STAGES-flop chain on pattern_raw; the FSM sees only the last stage (s). Edge 0 is the first edge that samples a new raw value; with SYNC_STAGES=2, s shows it after edge 1.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB, OFFER.
  - IDLE: s!=0 and entry_en=1 -> PRESS_DB; cand<=s; cnt<=1.
  - PRESS_DB: s==cand -> cnt++. When cnt reaches DEBOUNCE_CYCLES -> HELD; captured<=cand. s!=cand and s!=0 -> stay; cand<=s; cnt<=1. s==0 -> IDLE.
  - HELD: s==0 -> REL_DB; cnt<=1. Any non-zero s, including a different one, is ignored; captured stays frozen.
  - REL_DB: s==0 -> cnt++. When cnt reaches DEBOUNCE_CYCLES, evaluate legality with level sampled on that edge. Legal -> OFFER. Illegal -> IDLE, with out_illegal=1 for exactly the next cycle. s!=0 -> HELD (bounce; captured unchanged).
  - OFFER: out_valid=1; out_pattern=captured. out_valid&out_ready -> IDLE (transfer on that edge). pattern_raw is ignored in OFFER.
- Legality: level=1 -> always legal (captured is always non-zero). level=0 -> legal iff captured is one of 0001/0010/0100/1000.
- Release latency, SYNC_STAGES=2: out_valid rises after edge DEBOUNCE_CYCLES+1, counting edge 0 as the release sample. Press latency is the same.
- out_ready is ignored when out_valid=0. out_valid never drops without a transfer, except on entry_en=0 or reset.
- entry_en=0 (synchronous, highest priority after reset): from any state -> IDLE next edge; out_valid drops; no out_illegal. A press still held when entry_en returns is re-debounced from IDLE and yields a token only after its release.
- Counter width is clog2(DEBOUNCE_CYCLES+1). It never wraps, because every transition resets it.
- out_pattern holds its last captured value outside OFFER. Only out_valid qualifies it.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package simon_pkg holds:
  - the 3-bit state enum: IDLE=0, PRESS_DB=1, HELD=2, REL_DB=3, OFFER=4;
  - the one-hot legality function is_legal_pattern(pat, level), reused by the datapath checker;
  - the constant PATTERN_W=4.
- One sub-module, simon_sync: a parameterized N-stage synchronizer with active-low async reset to 0.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=4, level=0, entry_en=1. Raw 0100 for 10 cycles, then 0000. -> out_valid rises after edge 5 from the release sample, out_pattern=0100. With out_ready=1, it drops one cycle later; exactly one token.
- Bounce: raw 0010 for 2 cycles, 0000 for 1, then 0010 for 8, then 0000 with one 1-cycle 0010 glitch during release. -> One token 0010; no token from the first bounce; release restarts after the glitch.
- Illegal: level=0, raw 0110 held 8 cycles, then released. -> out_valid stays 0; out_illegal=1 for exactly one cycle. Repeat with level=1. -> token 0110, no out_illegal.
- Backpressure: token 1000 offered with out_ready=0 for 20 cycles while raw toggles 0001/0000. -> out_valid held, out_pattern=1000 throughout; single transfer when out_ready=1; no second token.
- Abort: entry_en dropped to 0 while in HELD, and separately in OFFER. -> IDLE next edge, out_valid=0, busy=0, no out_illegal.
- Reset mid-operation: assert rst_n=0 asynchronously in REL_DB. -> All outputs 0 immediately, with no clock edge needed. After deassert with raw=0, no spurious token.
